fifo_frame_writer: RTL and testbench
====================================

# fifo_frame_writer

Write-side producer for `stream_async_fifo`, running in the FIFO's write clock domain. It accepts a valid/ready byte stream with an end-of-frame marker and wraps each frame as header, payload, length and checksum words. It drives the FIFO write port and honours `w_full` on every word. A frame is only started when the FIFO reports room for a worst-case frame, so a reader on the far side never sees a frame stall for long mid-payload.

## Interface
- `DSIZE`, default 8: word width. Must match the FIFO's `DSIZE`.
- `ASIZE`, default 10: FIFO address width; FIFO capacity is 2**ASIZE. Must match the FIFO's `ASIZE`.
- `MAXLEN`, default 255: maximum payload words per frame. Constraint: 1 <= MAXLEN <= 2**DSIZE-1 and MAXLEN+3 <= 2**ASIZE.
- `rst_n`  in  1  reset, asynchronous, active-low
- `wclk`  in  1  clock; same clock as the FIFO `wclk`
- `s_valid`  in  1  upstream word valid
- `s_data`  in  DSIZE  upstream word
- `s_last`  in  1  last word of the frame; qualified by `s_valid`
- `s_ready`  out  1  upstream accept (combinational)
- `w_en`  out  1  FIFO write enable (registered)
- `wdata`  out  DSIZE  FIFO write data (registered)
- `w_full`  in  1  FIFO full (combinational from the FIFO)
- `wuse`  in  ASIZE  FIFO occupancy in the write domain (registered, lagging)
- `busy`  out  1  a frame is in progress (state != IDLE)
- `frame_done`  out  1  one-cycle pulse when a checksum word commits
- `trunc`  out  1  one-cycle pulse when a frame is closed at MAXLEN without `s_last`
- `seq`  out  DSIZE  sequence number of the next or current frame

## Operation
- Frame format, in order:
  - header word = `seq`
  - payload words, 1..MAXLEN of them
  - length word = payload count
  - checksum word = XOR of all payload words
- A word *commits* on a `wclk` edge where `w_en & ~w_full`. While `w_full` is high, `w_en`/`wdata` hold their values. This gives `out_free = ~w_en | ~w_full`.
- Room check: `room = ~w_full & (wuse <= 2**ASIZE-(MAXLEN+3))`. `w_full` is part of the check because `wuse` reads 0 when the FIFO is full.
- States:
  - **IDLE**: `w_en`=0, `s_ready`=0. If `s_valid & room`: load the header into the output register and go to PAY. The upstream word is not consumed.
  - **PAY**: `s_ready = out_free`.
    - On `s_valid & s_ready`: output register <= `s_data`, cnt += 1, sum ^= `s_data`.
    - If `s_last` or cnt+1 == MAXLEN, go to LEN. `trunc` pulses when the MAXLEN limit closes the frame and `s_last` is 0.
    - If `out_free & ~s_valid`: `w_en` <= 0 (bubble).
  - **LEN**: when `out_free`, output register <= cnt, go to SUM.
  - **SUM**: when `out_free`, output register <= sum, go to DONE.
  - **DONE**: when `out_free`, `w_en` <= 0, seq += 1 (wraps mod 2**DSIZE), cnt/sum cleared, `frame_done` pulses, go to IDLE.
- After truncation, the remaining upstream words start a new frame with the next `seq`.
- Payload length is never 0: a frame opens only when `s_valid` is high, and that word is taken next.

## Timing
- Reset values: `w_en`=0, `wdata`=0, `s_ready`=0, `busy`=0, `frame_done`=0, `trunc`=0, `seq`=0; state=IDLE, cnt=0, sum=0.
- Header `w_en` rises 1 cycle after the admit edge.
- With no `w_full` and continuous `s_valid`, one word commits per cycle. An N-word frame occupies N+3 write cycles plus 1 IDLE cycle before the next header.
- `frame_done` is high in the cycle after the checksum commit edge.
- `s_ready` depends combinationally on `w_full`, `w_en` and state only, never on `s_valid`.
- `w_full` high for K cycles stalls the output register for exactly K cycles. No word is dropped or duplicated.
- Reset mid-frame abandons the frame immediately; the FIFO shares `rst_n` and clears too.

## Structure
- Shared package `fifo_frame_pkg`:
  - state enum {IDLE, PAY, LEN, SUM, DONE}
  - `FRAME_OVERHEAD` = 3
  - the field order above, so the matching reader-side parser uses the same definitions.
- Single module, no sub-modules; the output register is the only pipeline stage.

## Test plan
- Payload 0x11,0x22,0x33 (last on 0x33), FIFO empty -> FIFO holds 0x00,0x11,0x22,0x33,0x03,0x00; `frame_done` once; `seq`=1.
- Same frame with `w_full` forced high for 5 cycles while 0x22 is in the output register -> identical FIFO contents; `wdata` holds 0x22 for all 5 cycles.
- MAXLEN=4, 6-word stream 0x01..0x06 with last on 0x06 -> frame seq0 payload 0x01..0x04, len 0x04, sum 0x04; `trunc` pulses once; frame seq1 payload 0x05,0x06, len 0x02, sum 0x03.
- `wuse`=2**ASIZE-MAXLEN-2 with `s_valid` high -> stays in IDLE, `w_en`=0; drop `wuse` by 1 -> header commits.
- 256 back-to-back 1-word frames -> `seq` wraps 0xFF->0x00; every frame is 4 words with len 0x01.
- Assert `rst_n`=0 during PAY -> `w_en`, `busy`, `seq` read 0 within the reset window; a new frame after release starts with header 0x00.

Source files
------------

// File: rtl/fifo_frame_pkg.sv
// fifo_frame_pkg: shared frame definitions for the stream_async_fifo writer and reader
package fifo_frame_pkg;
  typedef enum logic [2:0] {IDLE, PAY, LEN, SUM, DONE} state_t;
  typedef enum logic [1:0] {FLD_HDR, FLD_PAY, FLD_LEN, FLD_SUM} field_t;
  localparam int FRAME_OVERHEAD = 3;
  function automatic int frame_words(input int len);
    return len + FRAME_OVERHEAD;
  endfunction
endpackage

// File: rtl/fifo_frame_writer.sv
// fifo_frame_writer: frames a valid/ready byte stream as header, payload, length, checksum into stream_async_fifo
module fifo_frame_writer
  import fifo_frame_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int ASIZE  = 10,
  parameter int MAXLEN = 255
) (
  input  logic             wclk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             w_en,
  output logic [DSIZE-1:0] wdata,
  input  logic             w_full,
  input  logic [ASIZE-1:0] wuse,
  output logic             busy,
  output logic             frame_done,
  output logic             trunc,
  output logic [DSIZE-1:0] seq
);
  localparam logic [ASIZE:0] ROOM_MAX = (ASIZE+1)'(2**ASIZE - frame_words(MAXLEN));
  localparam logic [DSIZE-1:0] LAST_IDX = DSIZE'(MAXLEN - 1);
  state_t state, state_d;
  logic [DSIZE-1:0] cnt, cnt_d, sum, sum_d, seq_d, wdata_d;
  logic w_en_d, done_d, trunc_d, out_free, room, at_max;
  assign out_free = ~w_en | ~w_full;
  assign room = ~w_full & ({1'b0, wuse} <= ROOM_MAX);
  assign at_max = cnt == LAST_IDX;
  assign s_ready = (state == PAY) & out_free;
  assign busy = state != IDLE;
  // next frame step; the output register only moves when the FIFO can take the held word
  always_comb begin
    state_d = state;
    w_en_d = w_en;
    wdata_d = wdata;
    cnt_d = cnt;
    sum_d = sum;
    seq_d = seq;
    done_d = 1'b0;
    trunc_d = 1'b0;
    case (state)
      IDLE: begin
        w_en_d = 1'b0;
        if (s_valid & room) begin
          state_d = PAY;
          w_en_d = 1'b1;
          wdata_d = seq;
        end
      end
      PAY:
        if (s_valid & out_free) begin
          w_en_d = 1'b1;
          wdata_d = s_data;
          cnt_d = cnt + DSIZE'(1);
          sum_d = sum ^ s_data;
          state_d = (s_last | at_max) ? LEN : PAY;
          trunc_d = at_max & ~s_last;
        end else if (out_free) w_en_d = 1'b0;
      LEN:
        if (out_free) begin
          w_en_d = 1'b1;
          wdata_d = cnt;
          state_d = SUM;
        end
      SUM:
        if (out_free) begin
          wdata_d = sum;
          state_d = DONE;
        end
      DONE:
        if (out_free) begin
          w_en_d = 1'b0;
          seq_d = seq + DSIZE'(1);
          cnt_d = '0;
          sum_d = '0;
          done_d = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  // state and output register; reset abandons any frame in flight
  always_ff @(posedge wclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      w_en <= 1'b0;
      wdata <= '0;
      cnt <= '0;
      sum <= '0;
      seq <= '0;
      frame_done <= 1'b0;
      trunc <= 1'b0;
    end else begin
      state <= state_d;
      w_en <= w_en_d;
      wdata <= wdata_d;
      cnt <= cnt_d;
      sum <= sum_d;
      seq <= seq_d;
      frame_done <= done_d;
      trunc <= trunc_d;
    end
endmodule

// File: tb/tb_fifo_frame_writer.sv
// tb_fifo_frame_writer: randomized scoreboard bench for fifo_frame_writer against a frame-level model
module tb_fifo_frame_writer;
  localparam int MAXLEN = 4;
  logic wclk, rst_n, s_valid, s_last, s_ready, w_en, w_full, busy, frame_done, trunc;
  logic [7:0] s_data, wdata, seq;
  logic [3:0] wuse;
  logic [7:0] exp_q[$];
  logic [7:0] seq_m;
  logic [7:0] q[$];
  int n_checks, n_fail, exp_done, got_done, exp_trunc, got_trunc;
  bit mon_en, rand_full;

  fifo_frame_writer #(.DSIZE(8), .ASIZE(4), .MAXLEN(MAXLEN)) dut (
    .wclk(wclk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .w_en(w_en), .wdata(wdata), .w_full(w_full), .wuse(wuse),
    .busy(busy), .frame_done(frame_done), .trunc(trunc), .seq(seq)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference: split the stream into frames of at most MAXLEN words, each wrapped as seq, payload, length, xor
  task automatic model(input logic [7:0] d[$]);
    int i;
    int n;
    logic [7:0] x;
    i = 0;
    while (i < d.size()) begin
      n = (d.size() - i > MAXLEN) ? MAXLEN : d.size() - i;
      x = 8'h00;
      exp_q.push_back(seq_m);
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(d[i+k]);
        x ^= d[i+k];
      end
      exp_q.push_back(8'(n));
      exp_q.push_back(x);
      if (i + n < d.size()) exp_trunc++;
      exp_done++;
      seq_m++;
      i += n;
    end
  endtask

  task automatic drive(input logic [7:0] d[$], input int gapmax);
    int g;
    int t;
    bit hs;
    for (int i = 0; i < d.size(); i++) begin
      g = $urandom_range(0, gapmax);
      if (g > 0) begin
        s_valid = 1'b0;
        repeat (g) @(negedge wclk);
      end
      s_valid = 1'b1;
      s_data = d[i];
      s_last = (i == d.size() - 1);
      t = 0;
      hs = 1'b0;
      while (!hs && t < 500) begin
        #4;
        hs = s_ready;
        @(negedge wclk);
        t++;
      end
      if (!hs) chk("accept_timeout", 32'(t), 0);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send(input logic [7:0] d[$], input int gapmax);
    model(d);
    drive(d, gapmax);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 300 && (exp_q.size() != 0 || busy)) begin
      @(negedge wclk);
      #4;
      t++;
    end
    chk("drain_timeout", 32'(t < 300), 1);
    repeat (2) @(negedge wclk);
  endtask

  // monitor: every word the FIFO would accept is popped from the scoreboard
  initial forever begin
    @(negedge wclk);
    #4;
    if (mon_en && rst_n) begin
      if (frame_done) got_done++;
      if (trunc) got_trunc++;
      if (w_en && !w_full) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got 0x%0h, expected none", wdata);
        end else chk("fifo_word", 32'(wdata), 32'(exp_q.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge wclk);
    if (rand_full) w_full = ($urandom_range(0, 2) == 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; exp_done = 0; got_done = 0; exp_trunc = 0; got_trunc = 0;
    seq_m = 8'h00; mon_en = 1'b1; rand_full = 1'b0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; w_full = 1'b0; wuse = 4'd0;
    repeat (3) @(negedge wclk);
    #4;
    chk("rst_w_en", 32'(w_en), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_trunc", 32'(trunc), 0);
    chk("rst_seq", 32'(seq), 0);
    @(negedge wclk);
    rst_n = 1'b1;
    @(negedge wclk);
    q = {8'h11, 8'h22, 8'h33};
    send(q, 0);
    wait_idle();
    chk("t1_seq", 32'(seq), 1);
    chk("t1_done_count", 32'(got_done), 1);
    q = {8'h11, 8'h22, 8'h33};
    fork
      send(q, 0);
      begin
        int t;
        t = 0;
        #2;
        while (t < 100 && !(w_en && wdata == 8'h22)) begin
          @(negedge wclk);
          #2;
          t++;
        end
        chk("stall_reached", 32'(t < 100), 1);
        w_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          chk("stall_hold", 32'(wdata), 'h22);
          @(negedge wclk);
          #2;
        end
        w_full = 1'b0;
      end
    join
    @(negedge wclk);
    wait_idle();
    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(q, 0);
    wait_idle();
    chk("trunc_count", 32'(got_trunc), 1);
    wuse = 4'd10;
    fork
      begin
        q = {8'h5A};
        send(q, 0);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          #4;
          chk("noroom_w_en", 32'(w_en), 0);
          chk("noroom_busy", 32'(busy), 0);
          @(negedge wclk);
        end
        wuse = 4'd9;
      end
    join
    wait_idle();
    wuse = 4'd0;
    rand_full = 1'b1;
    for (int f = 0; f < 20; f++) begin
      q.delete();
      for (int k = 0, n = $urandom_range(1, 7); k < n; k++) q.push_back(8'($urandom));
      send(q, 2);
    end
    wait_idle();
    rand_full = 1'b0;
    w_full = 1'b0;
    for (int f = 0; f < 256; f++) begin
      q = {8'(f)};
      send(q, 0);
    end
    wait_idle();
    chk("wrap_seq", 32'(seq), 32'(seq_m));
    chk("done_count", 32'(got_done), 32'(exp_done));
    chk("trunc_total", 32'(got_trunc), 32'(exp_trunc));
    chk("queue_empty", 32'(exp_q.size()), 0);
    mon_en = 1'b0;
    s_valid = 1'b1; s_data = 8'hA1; s_last = 1'b0;
    repeat (3) @(negedge wclk);
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #4;
    chk("midrst_w_en", 32'(w_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_seq", 32'(seq), 0);
    s_valid = 1'b0;
    @(negedge wclk);
    rst_n = 1'b1;
    exp_q.delete();
    seq_m = 8'h00;
    mon_en = 1'b1;
    @(negedge wclk);
    q = {8'h77, 8'h88};
    send(q, 1);
    wait_idle();
    chk("post_rst_seq", 32'(seq), 1);
    chk("final_done_count", 32'(got_done), 32'(exp_done));
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
